// File: rtl/clk_en_ctrl.sv
// clk_en_ctrl: clock-enable and reset sequencer for the peripheral domains.
//
// After reset (or a soft reset) all peripheral resets are held low for
// RST_CYCLES clocks. They are then released one channel per clock, ch0 first.
// Once the last channel is out of reset the block is in RUN. In RUN each
// channel produces a one-cycle clock-enable pulse every div+1 clocks.
//
// Ports
//   Clk       system clock
//   Rst_n     asynchronous active-low reset (clears everything, incl. config)
//   Sw_Rst    synchronous soft reset; keeps div/en, restarts the sequence
//   Cfg_Wr    configuration write strobe (honoured only in RUN)
//   Cfg_Ch    target channel index
//   Cfg_Div   divide value; enable period is Cfg_Div+1 clocks
//   Cfg_En    channel enable
//   Cfg_Ack   one-cycle pulse: write accepted
//   Cfg_Err   one-cycle pulse: write rejected (channel out of range)
//   Ch_Ce     per-channel clock-enable pulses
//   Ch_Rst_n  per-channel active-low resets
//   Ready     high while in RUN
module clk_en_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 8,
  parameter int RST_CYCLES = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Sw_Rst,
  input  logic              Cfg_Wr,
  input  logic [2:0]        Cfg_Ch,
  input  logic [DIV_W-1:0]  Cfg_Div,
  input  logic              Cfg_En,
  output logic              Cfg_Ack,
  output logic              Cfg_Err,
  output logic [NUM_CH-1:0] Ch_Ce,
  output logic [NUM_CH-1:0] Ch_Rst_n,
  output logic              Ready
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DIV_W-1:0]    div [NUM_CH];
  logic [DIV_W-1:0]    cnt [NUM_CH];
  logic [NUM_CH-1:0]   en;

  logic                wr_ok;
  logic                ch_ok;
  logic [NUM_CH-1:0]   wr_hit;

  // A write is only serviced in RUN, and a simultaneous soft reset drops it.
  always_comb begin
    wr_ok  = Cfg_Wr && (state == S_RUN) && !Sw_Rst;
    ch_ok  = int'(Cfg_Ch) < NUM_CH;
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = wr_ok && (Cfg_Ch == 3'(i));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= S_HOLD;
      hold_cnt <= '0;
      Ch_Rst_n <= '0;
      Ch_Ce    <= '0;
      Ready    <= 1'b0;
      Cfg_Ack  <= 1'b0;
      Cfg_Err  <= 1'b0;
      en       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        div[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      Cfg_Ack <= 1'b0;
      Cfg_Err <= 1'b0;
      if (Sw_Rst) begin
        // div/en survive so channels resume at phase 0 on the next RUN.
        state    <= S_HOLD;
        hold_cnt <= '0;
        Ch_Rst_n <= '0;
        Ch_Ce    <= '0;
        Ready    <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          cnt[i] <= '0;
        end
      end else begin
        case (state)
          S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              state <= S_RELEASE;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            // Shift ones in from ch0; when the next-to-last bit is already
            // set, this edge releases the last channel and enters RUN.
            Ch_Rst_n <= {Ch_Rst_n[NUM_CH-2:0], 1'b1};
            if (Ch_Rst_n[NUM_CH-2]) begin
              state <= S_RUN;
              Ready <= 1'b1;
            end
          end
          S_RUN: begin
            Cfg_Ack <= wr_ok && ch_ok;
            Cfg_Err <= wr_ok && !ch_ok;
          end
          default: begin
            state <= S_HOLD;
          end
        endcase

        for (int i = 0; i < NUM_CH; i++) begin
          if (wr_hit[i]) begin
            // Restart the phase without emitting a partial pulse.
            div[i]   <= Cfg_Div;
            en[i]    <= Cfg_En;
            cnt[i]   <= '0;
            Ch_Ce[i] <= 1'b0;
          end else if (!en[i] || (state != S_RUN)) begin
            cnt[i]   <= '0;
            Ch_Ce[i] <= 1'b0;
          end else if (cnt[i] == div[i]) begin
            cnt[i]   <= '0;
            Ch_Ce[i] <= 1'b1;
          end else begin
            cnt[i]   <= cnt[i] + 1'b1;
            Ch_Ce[i] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_en_ctrl.sv
// Directed bench for clk_en_ctrl with NUM_CH=4, DIV_W=8, RST_CYCLES=16.
module tb_clk_en_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Sw_Rst;
  logic       Cfg_Wr;
  logic [2:0] Cfg_Ch;
  logic [7:0] Cfg_Div;
  logic       Cfg_En;
  logic       Cfg_Ack;
  logic       Cfg_Err;
  logic [3:0] Ch_Ce;
  logic [3:0] Ch_Rst_n;
  logic       Ready;

  int n_cmp = 0;
  int n_bad = 0;

  clk_en_ctrl #(.NUM_CH(4), .DIV_W(8), .RST_CYCLES(16)) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Sw_Rst   (Sw_Rst),
    .Cfg_Wr   (Cfg_Wr),
    .Cfg_Ch   (Cfg_Ch),
    .Cfg_Div  (Cfg_Div),
    .Cfg_En   (Cfg_En),
    .Cfg_Ack  (Cfg_Ack),
    .Cfg_Err  (Cfg_Err),
    .Ch_Ce    (Ch_Ce),
    .Ch_Rst_n (Ch_Rst_n),
    .Ready    (Ready)
  );

  always #5 Clk = ~Clk;

  // One active edge, then settle on the falling edge for sampling/driving.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ce, input logic [3:0] rstn,
                         input logic rdy, input logic ack, input logic err);
    chk({tag, ".ce"},   32'(Ch_Ce),    32'(ce));
    chk({tag, ".rstn"}, 32'(Ch_Rst_n), 32'(rstn));
    chk({tag, ".rdy"},  32'(Ready),    32'(rdy));
    chk({tag, ".ack"},  32'(Cfg_Ack),  32'(ack));
    chk({tag, ".err"},  32'(Cfg_Err),  32'(err));
  endtask

  task automatic wr(input logic [2:0] ch, input logic [7:0] dv, input logic e);
    Cfg_Wr  = 1'b1;
    Cfg_Ch  = ch;
    Cfg_Div = dv;
    Cfg_En  = e;
    tick();
    Cfg_Wr  = 1'b0;
  endtask

  // Expected reset-release pattern after n edges from HOLD entry.
  function automatic logic [3:0] rel_pat(input int n);
    if (n <= 16) return 4'b0000;
    if (n == 17) return 4'b0001;
    if (n == 18) return 4'b0011;
    if (n == 19) return 4'b0111;
    return 4'b1111;
  endfunction

  initial begin
    Rst_n   = 1'b0;
    Sw_Rst  = 1'b0;
    Cfg_Wr  = 1'b0;
    Cfg_Ch  = '0;
    Cfg_Div = '0;
    Cfg_En  = 1'b0;

    // Reset values
    tick();
    tick();
    chk_all("reset", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Power-up sequence, with a ch0 write held on the whole time: it must be
    // dropped in HOLD and RELEASE.
    Rst_n   = 1'b1;
    Cfg_Wr  = 1'b1;
    Cfg_Ch  = 3'd0;
    Cfg_Div = 8'd0;
    Cfg_En  = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("pwr%0d", n), {Ch_Rst_n, Ready, Cfg_Ack, Cfg_Err},
          {rel_pat(n), (n == 20), 1'b0, 1'b0});
    end
    Cfg_Wr = 1'b0;
    tick();
    tick();
    chk("hold_wr_dropped", 32'(Ch_Ce), 32'd0);

    // ch2 Div=3: pulses after E+4, E+8, E+12
    wr(3'd2, 8'd3, 1'b1);
    chk_all("ch2_E", 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("ch2_E+%0d", k), {Ch_Ce, Cfg_Ack},
          {((k % 4) == 0) ? 4'b0100 : 4'b0000, 1'b0});
    end
    wr(3'd2, 8'd3, 1'b0);
    tick();
    chk("ch2_off", 32'(Ch_Ce), 32'd0);

    // ch1 Div=0: constant enable from E+1, then disable
    wr(3'd1, 8'd0, 1'b1);
    chk("ch1_ack", 32'(Cfg_Ack), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("ch1_E+%0d", k), 32'(Ch_Ce), 32'b0010);
    end
    wr(3'd1, 8'd0, 1'b0);
    chk("ch1_off_ack", 32'(Cfg_Ack), 32'd1);
    tick();
    chk("ch1_off", 32'(Ch_Ce), 32'd0);

    // Out-of-range channel
    wr(3'd5, 8'd1, 1'b1);
    chk_all("bad_ch", 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    tick();
    chk_all("bad_ch+1", 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("bad_ch_nochg", 32'(Ch_Ce), 32'd0);

    // ch0 Div=2, then Sw_Rst together with a ch0 Div=7 write
    wr(3'd0, 8'd2, 1'b1);
    tick();
    chk("ch0_J+1", 32'(Ch_Ce), 32'd0);
    tick();
    chk("ch0_J+2", 32'(Ch_Ce), 32'd0);
    tick();
    chk("ch0_J+3", 32'(Ch_Ce), 32'b0001);
    Sw_Rst = 1'b1;
    wr(3'd0, 8'd7, 1'b1);
    Sw_Rst = 1'b0;
    chk_all("swrst_S", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("swrst%0d", n), {Ch_Rst_n, Ready, Ch_Ce}, {rel_pat(n), (n == 20), 4'b0000});
    end
    tick();
    chk("resume_R+1", 32'(Ch_Ce), 32'd0);
    tick();
    chk("resume_R+2", 32'(Ch_Ce), 32'd0);
    tick();
    chk("resume_R+3", 32'(Ch_Ce), 32'b0001);

    // Asynchronous reset mid-cycle while ch0 pulse is high
    #2 Rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
    end
    chk("rerun_rstn", {Ch_Rst_n, Ready}, {4'b1111, 1'b1});
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("en_cleared%0d", k), 32'(Ch_Ce), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_en_ctrl.md
Name: clk_en_ctrl

Overview:
Clock-enable and reset sequencer for the microcontroller's peripheral domains, all running on the single system clock Clk. After reset it holds the peripheral resets for a fixed time, then releases them one channel per cycle. In run mode it generates a programmable divided clock-enable pulse per channel. Its configuration port is written by the CPU or the testbench.

Parameters:
NUM_CH, 4, number of peripheral channels (2..8)
DIV_W, 8, width of the per-channel divide value
RST_CYCLES, 16, cycles Ch_Rst_n is held low after reset or soft reset (>=1)

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
Sw_Rst  input  1  synchronous soft-reset request, 1-cycle pulse
Cfg_Wr  input  1  configuration write strobe
Cfg_Ch  input  3  target channel index
Cfg_Div  input  DIV_W  divide value; Ch_Ce period is Cfg_Div+1 cycles
Cfg_En  input  1  channel enable
Cfg_Ack  output  1  1-cycle pulse: write accepted
Cfg_Err  output  1  1-cycle pulse: write rejected (Cfg_Ch >= NUM_CH)
Ch_Ce  output  NUM_CH  per-channel clock-enable pulses
Ch_Rst_n  output  NUM_CH  per-channel active-low resets
Ready  output  1  high while in RUN

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst_n is asynchronous and active-low. All outputs are registered.
- Values while Rst_n is low: Ch_Ce=0, Ch_Rst_n=0, Ready=0, Cfg_Ack=0, Cfg_Err=0. Internal div[*]=0, en[*]=0, cnt[*]=0. State is HOLD with hold counter 0.
- HOLD state:
  - Count cycles starting at the first edge after Rst_n rises.
  - After RST_CYCLES edges, go to RELEASE.
  - Ch_Rst_n stays all-zero.
- RELEASE state:
  - One channel's reset is released per edge, in index order, ch0 first.
  - After the edge that sets Ch_Rst_n[NUM_CH-1]=1, go to RUN.
  - Ready=1 in the same cycle that the last reset is released.
- RUN state: Ready=1. Config writes are serviced only in this state.
- Config write (Cfg_Wr=1 in RUN):
  - If Cfg_Ch < NUM_CH: div[ch]<=Cfg_Div, en[ch]<=Cfg_En, cnt[ch]<=0. Cfg_Ack=1 on the next cycle.
  - Otherwise: no state change. Cfg_Err=1 on the next cycle.
  - Cfg_Wr outside RUN is dropped silently: no Ack, no Err.
- Per-channel divider, every edge:
  - If !en or state!=RUN: cnt<=0, Ch_Ce<=0.
  - Else if cnt==div: cnt<=0, Ch_Ce<=1.
  - Else: cnt<=cnt+1, Ch_Ce<=0.
- Divider timing:
  - If a write is sampled at edge E, the first Ch_Ce pulse is high after edge E+Div+1.
  - The period is then Div+1 cycles.
  - Div=0 gives Ch_Ce continuously high.
  - A rewrite of a running channel restarts its phase; no partial pulse is emitted.
  - Writing Cfg_En=0 clears Ch_Ce after the next edge.
- Soft reset (Sw_Rst=1 in any state):
  - Next state is HOLD; hold counter, Ch_Rst_n, Ch_Ce, Ready and cnt[*] are cleared.
  - div[*] and en[*] are retained, so dividers resume at phase 0 when the FSM re-enters RUN.
  - Sw_Rst asserted in the same cycle as Cfg_Wr: Sw_Rst wins and the write is dropped.
  - Sw_Rst asserted during HOLD restarts the hold count.
- Rst_n asserted mid-operation: all state is cleared immediately, asynchronously, including div and en.
- Hold counter width: clog2(RST_CYCLES+1). cnt width: DIV_W; it never exceeds div, so there is no wrap-around.

Test Plan:
- Power-up, RST_CYCLES=16, NUM_CH=4: release Rst_n -> Ch_Rst_n=0000 for 16 edges, then 0001, 0011, 0111, 1111 on consecutive edges; Ready=1 with 1111.
- In RUN, write ch2 Div=3 En=1 at edge E -> Cfg_Ack high one cycle; Ch_Ce[2] high after E+4, E+8, E+12; other channels stay 0.
- Write ch1 Div=0 En=1 -> Ch_Ce[1] constantly high from E+1. Then write ch1 En=0 -> Ch_Ce[1]=0 after the next edge.
- Write Cfg_Ch=5 -> Cfg_Err=1 for one cycle, Cfg_Ack=0, no channel changes. A write during HOLD -> neither Ack nor Err.
- ch0 Div=2 running; Sw_Rst together with a Cfg_Wr to ch0 Div=7 -> write dropped, Ready=0, Ch_Rst_n=0000 for 16 cycles, re-release in order; first Ch_Ce[0] pulse 3 cycles after Ready.
- Drop Rst_n asynchronously mid-period -> all outputs 0 immediately. After release and sequencing, Ch_Ce stays 0 because en was cleared.
